// File: rtl/tdm_demux1x4_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
package tdm_demux1x4_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_demux1x4_slot_counter.sv
// Slot counter (modulo NUM_SLOTS) with clear, load-to-1 and increment; clear wins over load, load over increment.
module tdm_slot_counter
  import tdm_demux1x4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load1,
  input  logic              en,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SLOT_W'(1);
    end else if (en) begin
      slot_d = SLOT_W'(slot_q + SLOT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux1x4.sv
// Rebuilds four parallel channels from a slot-ordered TDM stream aligned by a frame-sync marker.
module tdm_demux1x4
  import tdm_demux1x4_pkg::*;
#(
  parameter int unsigned WIDTH        = 1,
  parameter bit          REQUIRE_SYNC = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic             S1,
  output logic             S0,
  output logic             locked,
  output logic             sync_err
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0]  y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic              frame_valid_q, frame_valid_d;
  logic              sync_err_q, sync_err_d;
  logic              locked_q;
  logic              cnt_clr, cnt_load1, cnt_en;
  logic [SLOT_W-1:0] slot;

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .en    (cnt_en),
    .slot  (slot)
  );

  // Next-state, capture and counter control; `slot` is the slot expected for this beat.
  always_comb begin
    state_d       = state_q;
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    sh2_d         = sh2_q;
    y0_d          = y0_q;
    y1_d          = y1_q;
    y2_d          = y2_q;
    y3_d          = y3_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    cnt_clr       = 1'b0;
    cnt_load1     = 1'b0;
    cnt_en        = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            sh0_d     = din;
            cnt_load1 = 1'b1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (slot == '0) begin
            if (sync || !REQUIRE_SYNC) begin
              sh0_d     = din;
              cnt_load1 = 1'b1;
            end else begin
              sync_err_d = 1'b1;
              cnt_clr    = 1'b1;
              state_d    = HUNT;
            end
          end else if (sync) begin
            // Early sync restarts the frame here; the partial frame is dropped.
            sync_err_d = 1'b1;
            sh0_d      = din;
            cnt_load1  = 1'b1;
          end else begin
            cnt_en = 1'b1;
            unique case (slot)
              SLOT_W'(1): sh1_d = din;
              SLOT_W'(2): sh2_d = din;
              default: begin
                y0_d          = sh0_q;
                y1_d          = sh1_q;
                y2_d          = sh2_q;
                y3_d          = din;
                frame_valid_d = 1'b1;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      y0_q          <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      y3_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      y0_q          <= y0_d;
      y1_q          <= y1_d;
      y2_q          <= y2_d;
      y3_q          <= y3_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= (state_d == LOCKED);
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = locked_q;
  assign S1          = slot[1];
  assign S0          = slot[0];

endmodule
